// File: rtl/cpu_stim_checker.sv
// rtl/cpu_stim_checker.sv - program ROM, ReadData pattern and store checker around the single-cycle core

module cpu_stim_checker #(
    parameter int              XLEN         = 32,
    parameter int              PROG_DEPTH   = 64,
    parameter int              CHK_DEPTH    = 16,
    parameter int              RESET_CYCLES = 2,
    parameter int              MAX_CYCLES   = 256,
    parameter logic [XLEN-1:0] RD_PATTERN   = 32'hA5A5_0000,
    parameter logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013,
    localparam int PAW = $clog2(PROG_DEPTH),
    localparam int CAW = $clog2(CHK_DEPTH),
    localparam int AW  = (PAW > CAW) ? PAW : CAW,
    localparam int CW  = CAW + 1,
    localparam int YW  = $clog2(MAX_CYCLES) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_en,
    input  logic            ld_sel,
    input  logic [AW-1:0]   ld_addr,
    input  logic [2*XLEN-1:0] ld_data,
    input  logic [CW-1:0]   num_chk,
    input  logic            start,
    output logic            cpu_reset,
    input  logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] Instr,
    input  logic            MemWrite,
    input  logic [XLEN-1:0] ALUResult,
    input  logic [XLEN-1:0] WriteData,
    output logic [XLEN-1:0] ReadData,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [CW-1:0]   pass_cnt,
    output logic [CW-1:0]   fail_cnt,
    output logic [YW-1:0]   cycle_cnt
);

    localparam int HW = $clog2(RESET_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

    state_t            state, state_nx;
    logic [XLEN-1:0]   rom [PROG_DEPTH];
    logic [2*XLEN-1:0] tbl [CHK_DEPTH];
    logic [CW-1:0]     num_l;
    logic [CW-1:0]     chk_ptr;
    logic [CW-1:0]     pass_r;
    logic [CW-1:0]     fail_r;
    logic [YW-1:0]     cyc_r;
    logic [HW-1:0]     hold_cnt;
    logic              timeout_r;
    logic              oob;

    logic idle_like, go, wr, in_run, pc_ok;
    logic store_chk, store_hit, complete, last_cyc;

    // DONE behaves like IDLE for loading and restarting
    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign go        = start && idle_like;
    assign wr        = ld_en && idle_like;
    assign in_run    = (state == S_RUN);

    assign store_chk = in_run && MemWrite && (chk_ptr < num_l);
    assign store_hit = store_chk && ({ALUResult, WriteData} == tbl[chk_ptr[CAW-1:0]]);
    assign complete  = store_chk && ((chk_ptr + CW'(1)) == num_l);
    assign last_cyc  = (cyc_r == YW'(MAX_CYCLES - 1));

    assign pc_ok    = (PC[1:0] == 2'b00) && (PC[XLEN-1:PAW+2] == '0);
    assign Instr    = pc_ok ? rom[PC[PAW+1:2]] : NOP_INSTR;
    assign ReadData = ALUResult ^ RD_PATTERN;

    assign cpu_reset = !in_run;
    assign busy      = (state == S_HOLD) || in_run;
    assign done      = (state == S_DONE);
    assign timeout   = timeout_r;
    assign pass_cnt  = pass_r;
    assign fail_cnt  = fail_r;
    assign cycle_cnt = cyc_r;
    assign pass      = done && (fail_r == '0) && !timeout_r && (pass_r == num_l);

    always_ff @(posedge clk) begin
        if (wr) begin
            if (!ld_sel) rom[ld_addr[PAW-1:0]] <= ld_data[XLEN-1:0];
            else         tbl[ld_addr[CAW-1:0]] <= ld_data;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_HOLD;
            S_HOLD:  if (hold_cnt == HW'(RESET_CYCLES - 1)) state_nx = S_RUN;
            S_RUN:   if (complete || last_cyc) state_nx = S_DONE;
            S_DONE:  if (start) state_nx = S_HOLD;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_l     <= '0;
            chk_ptr   <= '0;
            pass_r    <= '0;
            fail_r    <= '0;
            cyc_r     <= '0;
            hold_cnt  <= '0;
            timeout_r <= 1'b0;
            oob       <= 1'b0;
        end else if (go) begin
            num_l     <= num_chk;
            chk_ptr   <= '0;
            pass_r    <= '0;
            fail_r    <= '0;
            cyc_r     <= '0;
            hold_cnt  <= '0;
            timeout_r <= 1'b0;
            oob       <= 1'b0;
        end else if (state == S_HOLD) begin
            hold_cnt <= hold_cnt + HW'(1);
        end else if (in_run) begin
            cyc_r <= cyc_r + YW'(1);
            if (store_chk) chk_ptr <= chk_ptr + CW'(1);
            // mismatches and extra stores both land in fail_cnt, which saturates
            if (store_hit)
                pass_r <= pass_r + CW'(1);
            else if (MemWrite && (fail_r != '1))
                fail_r <= fail_r + CW'(1);
            if (last_cyc && !complete) timeout_r <= 1'b1;
            oob <= oob | !pc_ok;
        end
    end

endmodule
